// File: rtl/fib_pkg.sv
// fib_pkg: shared state encoding and sizing constants for the Fibonacci sequencer.
package fib_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SEED,
        CALC,
        STORE,
        DONE,
        ERR
    } fib_state_t;

    localparam int FIB_DW    = 12;
    localparam int FIB_IW    = 5;
    // Largest n whose F(n) still fits in FIB_DW bits.
    localparam int FIB_MAX_N = 18;

endpackage

// File: rtl/fib_step_cnt.sv
// fib_step_cnt: loadable down-counter holding the remaining Fibonacci step count.
module fib_step_cnt #(
    parameter int IW = 5
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          load_i,
    input  logic          dec_i,
    input  logic [IW-1:0] val_i,
    output logic [IW-1:0] cnt_o,
    output logic          is_one_o,
    output logic          is_zero_o
);

    logic [IW-1:0] cnt_q, cnt_d;

    // Saturates at zero so a stray decrement can never wrap.
    always_comb cnt_d = load_i ? val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o     = cnt_q;
    assign is_one_o  = cnt_q == IW'(1);
    assign is_zero_o = cnt_q == '0;

endmodule

// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl: Moore control FSM sequencing the A/B/OUT registers and adder to form F(n).
// Outputs decode only from registered state so the negedge datapath sees stable controls.
module fib_seq_ctrl
    import fib_pkg::*;
#(
    parameter int IW = FIB_IW,
    parameter int DW = FIB_DW
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic [IW-1:0] n,
    input  logic          sum_ovf,
    output logic          clr_dp,
    output logic          sel_init,
    output logic          ld_a,
    output logic          ld_b,
    output logic          ld_out,
    output logic          busy,
    output logic          done,
    output logic          ovf,
    output logic [IW-1:0] iter
);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_INIT  = INIT;
    localparam logic [2:0] S_SEED  = SEED;
    localparam logic [2:0] S_CALC  = CALC;
    localparam logic [2:0] S_STORE = STORE;
    localparam logic [2:0] S_DONE  = DONE;
    localparam logic [2:0] S_ERR   = ERR;

    // Every index must be representable, and the datapath must be wide enough to hold a seed.
    if (DW < 2 || (2 ** IW) <= FIB_MAX_N) begin : g_index_range_below_overflow_point
    end

    logic [2:0]    state_q, state_d;
    logic          ovf_q, ovf_d;
    logic          accept, step_ovf;
    logic          cnt_is_one, cnt_is_zero;
    logic [IW-1:0] cnt;

    assign accept   = state_q == S_IDLE && start;
    // The carry of the final step is F(n+1), which never reaches A, so it is not an error.
    assign step_ovf = state_q == S_CALC && !cnt_is_one && sum_ovf;

    fib_step_cnt #(.IW(IW)) u_step_cnt (
        .clk       (clk),
        .clr       (clr),
        .load_i    (accept),
        .dec_i     (state_q == S_CALC),
        .val_i     (n),
        .cnt_o     (cnt),
        .is_one_o  (cnt_is_one),
        .is_zero_o (cnt_is_zero)
    );

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = start ? S_INIT : S_IDLE;
            S_INIT:  state_d = S_SEED;
            S_SEED:  state_d = cnt_is_zero ? S_STORE : S_CALC;
            S_CALC:  state_d = cnt_is_one ? S_STORE : sum_ovf ? S_ERR : S_CALC;
            S_STORE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Set on entry to ERR so the flag is already up while done pulses.
    always_comb ovf_d = accept ? 1'b0 : step_ovf ? 1'b1 : ovf_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    assign clr_dp   = state_q == S_INIT;
    assign sel_init = state_q == S_SEED;
    assign ld_a     = state_q == S_CALC;
    assign ld_b     = state_q == S_SEED || state_q == S_CALC;
    assign ld_out   = state_q == S_STORE;
    assign busy     = state_q != S_IDLE;
    assign done     = state_q == S_DONE || state_q == S_ERR;
    assign ovf      = ovf_q;
    assign iter     = cnt;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// tb_fib_seq_ctrl: directed checks of the sequencer driving a behavioural 12-bit Fibonacci datapath.
module tb_fib_seq_ctrl;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  n = '0;
    logic        sum_ovf;
    logic        clr_dp, sel_init, ld_a, ld_b, ld_out, busy, done, ovf;
    logic [4:0]  iter;

    logic [11:0] a_q = '0, b_q = '0, out_q = '0;
    logic        carry_q = 1'b0;
    logic [12:0] sum;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fib_seq_ctrl #(.IW(5), .DW(12)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .n        (n),
        .sum_ovf  (sum_ovf),
        .clr_dp   (clr_dp),
        .sel_init (sel_init),
        .ld_a     (ld_a),
        .ld_b     (ld_b),
        .ld_out   (ld_out),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .iter     (iter)
    );

    // Registers capture on negedge; the carry is latched with them so the FSM
    // sees the carry of the sum written in the step it is finishing.
    // OUT is written only by ld_out, so an aborted run leaves the last result.
    assign sum     = {1'b0, a_q} + {1'b0, b_q};
    assign sum_ovf = carry_q;

    always @(negedge clk) begin
        carry_q <= sum[12];
        if (clr_dp) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (ld_a) a_q <= b_q;
            if (ld_b) b_q <= sel_init ? 12'd1 : sum[11:0];
        end
        if (ld_out) out_q <= a_q;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Starts a run at the next negedge and samples each following negedge until done.
    task automatic run_fib(input logic [4:0] nv, output int lat, output logic [11:0] res,
                           output logic ov, output logic busy_ok);
        @(negedge clk);
        start = 1'b1;
        n = nv;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!done && lat < 60) begin
            busy_ok &= busy;
            @(negedge clk);
            lat++;
        end
        busy_ok &= busy;
        res = out_q;
        ov = ovf;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({clr_dp, sel_init, ld_a, ld_b, ld_out, busy, done, ovf, iter} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {clr_dp, sel_init, ld_a, ld_b, ld_out, busy, done, ovf, iter});
        end
        start = 1'b1;
        n = 5'd9;
        @(negedge clk);
        checks++;
        if ({busy, iter} !== 6'd0) begin
            failures++;
            $display("FAIL reset_beats_start: busy=%b iter=%0d expected 0/0", busy, iter);
        end
        start = 1'b0;
        clr = 1'b0;
    endtask

    task automatic test_controls();
        logic [7:0] exp_ctl [7] = '{8'b1000_0100, 8'b0101_0100, 8'b0011_0100, 8'b0011_0100,
                                    8'b0000_1100, 8'b0000_0110, 8'b0000_0000};
        logic [4:0] exp_it [7] = '{5'd2, 5'd2, 5'd2, 5'd1, 5'd0, 5'd0, 5'd0};
        @(negedge clk);
        start = 1'b1;
        n = 5'd2;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({clr_dp, sel_init, ld_a, ld_b, ld_out, busy, done, ovf, iter} !== {exp_ctl[k], exp_it[k]}) begin
                failures++;
                $display("FAIL controls_n2_cycle%0d: got ctl=%b iter=%0d expected ctl=%b iter=%0d",
                         k + 1, {clr_dp, sel_init, ld_a, ld_b, ld_out, busy, done, ovf}, iter,
                         exp_ctl[k], exp_it[k]);
            end
        end
    endtask

    task automatic test_small_n();
        int lat;
        logic [11:0] res;
        logic ov, bz;
        run_fib(5'd0, lat, res, ov, bz);
        checks++;
        if (lat !== 4 || res !== 12'd0 || bz !== 1'b1) begin
            failures++;
            $display("FAIL n0: latency=%0d out=%0d busy_ok=%b expected 4/0/1", lat, res, bz);
        end
        run_fib(5'd1, lat, res, ov, bz);
        checks++;
        if (lat !== 5 || res !== 12'd1 || ov !== 1'b0) begin
            failures++;
            $display("FAIL n1: latency=%0d out=%0d ovf=%b expected 5/1/0", lat, res, ov);
        end
    endtask

    task automatic test_n10();
        int lat;
        logic [11:0] res;
        logic ov, bz;
        run_fib(5'd10, lat, res, ov, bz);
        checks++;
        if (lat !== 14) begin
            failures++;
            $display("FAIL n10_latency: got %0d expected 14", lat);
        end
        checks++;
        if (bz !== 1'b1) begin
            failures++;
            $display("FAIL n10_busy: busy dropped during run (got %b expected 1)", bz);
        end
        checks++;
        if (res !== 12'd55 || ov !== 1'b0) begin
            failures++;
            $display("FAIL n10_result: out=%0d ovf=%b expected 55/0", res, ov);
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL n10_single_done: busy=%b done=%b expected 0/0", busy, done);
        end
    endtask

    task automatic test_max_n();
        int lat;
        logic [11:0] res;
        logic ov, bz;
        run_fib(5'd18, lat, res, ov, bz);
        checks++;
        if (res !== 12'hA18 || ov !== 1'b0 || lat !== 22) begin
            failures++;
            $display("FAIL n18: out=%0d ovf=%b latency=%0d expected 2584/0/22", res, ov, lat);
        end
    endtask

    task automatic test_overflow();
        int lat;
        logic [11:0] res;
        logic ov, bz;
        run_fib(5'd19, lat, res, ov, bz);
        checks++;
        if (ov !== 1'b1 || lat !== 21) begin
            failures++;
            $display("FAIL n19_err: ovf=%b latency=%0d expected 1/21", ov, lat);
        end
        checks++;
        if (res !== 12'd2584) begin
            failures++;
            $display("FAIL n19_out_held: out=%0d expected 2584", res);
        end
        @(negedge clk);
        checks++;
        if ({busy, done, ovf} !== 3'b001) begin
            failures++;
            $display("FAIL ovf_sticky: busy=%b done=%b ovf=%b expected 0/0/1", busy, done, ovf);
        end
        run_fib(5'd5, lat, res, ov, bz);
        checks++;
        if (ov !== 1'b0 || res !== 12'd5 || lat !== 9) begin
            failures++;
            $display("FAIL n5_after_err: ovf=%b out=%0d latency=%0d expected 0/5/9", ov, res, lat);
        end
    endtask

    task automatic test_clr_mid_calc();
        int lat;
        logic [11:0] res;
        logic ov, bz;
        @(negedge clk);
        start = 1'b1;
        n = 5'd12;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (iter !== 5'd9 || ld_a !== 1'b1) begin
            failures++;
            $display("FAIL clr_setup_4th_step: iter=%0d ld_a=%b expected 9/1", iter, ld_a);
        end
        #2 clr = 1'b1;
        #1;
        checks++;
        if ({clr_dp, sel_init, ld_a, ld_b, ld_out, busy, done, ovf, iter} !== 13'd0) begin
            failures++;
            $display("FAIL clr_async: got %b expected all zero",
                     {clr_dp, sel_init, ld_a, ld_b, ld_out, busy, done, ovf, iter});
        end
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL clr_idle: busy=%b expected 0", busy);
        end
        run_fib(5'd7, lat, res, ov, bz);
        checks++;
        if (res !== 12'd13 || lat !== 11 || ov !== 1'b0) begin
            failures++;
            $display("FAIL n7_after_clr: out=%0d latency=%0d ovf=%b expected 13/11/0", res, lat, ov);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        @(negedge clk);
        start = 1'b1;
        n = 5'd3;
        for (int r = 0; r < 2; r++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!done && k < 40);
            checks++;
            if (k !== 7 || out_q !== 12'd2) begin
                failures++;
                $display("FAIL b2b_run%0d: latency=%0d out=%0d expected 7/2", r, k, out_q);
            end
            @(negedge clk);
            if (r == 1) start = 1'b0;
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL b2b_idle_gap%0d: busy=%b expected 0", r, busy);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int k;
        @(negedge clk);
        start = 1'b1;
        n = 5'd6;
        @(negedge clk);
        k = 1;
        while (!done && k < 40) begin
            if (k == 4) begin
                checks++;
                if (iter !== 5'd5) begin
                    failures++;
                    $display("FAIL toggle_iter: iter=%0d expected 5", iter);
                end
            end
            start = k[0];
            n = 5'(31 - k);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        checks++;
        if (k !== 10 || out_q !== 12'd8 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL toggle_result: latency=%0d out=%0d ovf=%b expected 10/8/0", k, out_q, ovf);
        end
    endtask

    initial begin
        test_reset();
        test_controls();
        test_small_n();
        test_n10();
        test_max_n();
        test_overflow();
        test_clr_mid_calc();
        test_back_to_back();
        test_start_while_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
